// File: rtl/vslc_spi_eeprom_responder_if.sv
// SPI pin bundle plus backdoor load port for the EEPROM responder.
// master: the SPI controller / loader side. slave: the responder.
interface vslc_spi_eeprom_responder_if #(
  parameter int ADDR_W = 10
);
  logic              spi_sck;
  logic              spi_cs_n;
  logic              spi_copi;
  logic              spi_cipo;
  logic              spi_cipo_oe;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              busy;

  modport master (
    output spi_sck, spi_cs_n, spi_copi, load_en, load_addr, load_data,
    input  spi_cipo, spi_cipo_oe, busy
  );

  modport slave (
    input  spi_sck, spi_cs_n, spi_copi, load_en, load_addr, load_data,
    output spi_cipo, spi_cipo_oe, busy
  );
endinterface

// File: rtl/vslc_spi_eeprom_responder.sv
// SPI mode-0 target emulating a 25xx-style EEPROM for the VSLC core.
// Serves READ (0x03) with unbounded continuous read and address wrap.
// All SPI pins are oversampled by scan_cycle_clk through SYNC_STAGES flops.
// Optional build macro VSLC_EEPROM_WRITE_EN adds WREN (0x06) / WRITE (0x02);
// without it those opcodes fall into IGNORE.
//
// state  | meaning
// IDLE   | CS high, waiting for CS low
// OPCODE | shifting 8 opcode bits on SCK rise
// ADDR   | shifting 16 address bits on SCK rise
// DATA   | driving read bytes on SCK fall
// IGNORE | unknown opcode, consume SCK until CS high
// WRITE  | (write build only) shifting data bytes into the array
module vslc_spi_eeprom_responder #(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      scan_cycle_clk,
  input  logic                      rst_n,
  vslc_spi_eeprom_responder_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OPCODE = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_IGNORE = 3'd4;
`ifdef VSLC_EEPROM_WRITE_EN
  localparam logic [2:0] ST_WRITE  = 3'd5;
`endif

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic                   sck_prev;
  logic                   sck_s;
  logic                   cs_s;
  logic                   copi_s;
  logic                   sck_rise;
  logic                   sck_fall;

  logic [2:0]        state;
  logic [3:0]        bit_cnt;
  logic [6:0]        shift_sr;
  logic [7:0]        shift_byte;
  logic [ADDR_W-1:0] addr_reg;
  logic              rd_req;
  logic [7:0]        rd_q;
  logic              cipo;

  logic [7:0]        mem [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

`ifdef VSLC_EEPROM_WRITE_EN
  logic              wel;
  logic              is_write;
  logic              pw_en;
  logic [ADDR_W-1:0] pw_addr;
  logic [7:0]        pw_data;
`endif

  // Synchronize the asynchronous SPI pins and keep the previous SCK for edge detect.
  always_ff @(posedge scan_cycle_clk) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      copi_sync <= '0;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.spi_cs_n};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], bus.spi_copi};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign copi_s     = copi_sync[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_prev;
  assign sck_fall   = ~sck_s & sck_prev;
  assign shift_byte = {shift_sr, copi_s};

  // Protocol FSM; CS high takes priority over any SCK edge seen in the same cycle.
  always_ff @(posedge scan_cycle_clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= 4'd7;
      shift_sr <= '0;
      addr_reg <= '0;
      rd_req   <= 1'b0;
      cipo     <= 1'b0;
`ifdef VSLC_EEPROM_WRITE_EN
      wel      <= 1'b0;
      is_write <= 1'b0;
      pw_en    <= 1'b0;
      pw_addr  <= '0;
      pw_data  <= '0;
`endif
    end else begin
      rd_req <= 1'b0;
`ifdef VSLC_EEPROM_WRITE_EN
      pw_en  <= 1'b0;
`endif
      if (cs_s) begin
        state   <= ST_IDLE;
        bit_cnt <= 4'd7;
        cipo    <= 1'b0;
`ifdef VSLC_EEPROM_WRITE_EN
        if (is_write) wel <= 1'b0;
        is_write <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_OPCODE;
            bit_cnt <= 4'd7;
          end
          ST_OPCODE: if (sck_rise) begin
            shift_sr <= shift_byte[6:0];
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd15;
              state   <= ST_IGNORE;
              if (shift_byte == 8'h03) state <= ST_ADDR;
`ifdef VSLC_EEPROM_WRITE_EN
              if (shift_byte == 8'h02) begin
                state    <= ST_ADDR;
                is_write <= 1'b1;
              end
              if (shift_byte == 8'h06) wel <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
          ST_ADDR: if (sck_rise) begin
            // Upper address bits fall off the top of the shift.
            addr_reg <= {addr_reg[ADDR_W-2:0], copi_s};
            if (bit_cnt == 4'd0) begin
              bit_cnt <= 4'd7;
              state   <= ST_DATA;
              rd_req  <= 1'b1;
`ifdef VSLC_EEPROM_WRITE_EN
              if (is_write) state <= ST_WRITE;
`endif
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
          ST_DATA: if (sck_fall) begin
            cipo <= rd_q[bit_cnt[2:0]];
            if (bit_cnt == 4'd0) begin
              // Last bit is already on the pin, so rd_q is free for the prefetch.
              bit_cnt  <= 4'd7;
              addr_reg <= addr_reg + 1'b1;
              rd_req   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
`ifdef VSLC_EEPROM_WRITE_EN
          ST_WRITE: if (sck_rise) begin
            shift_sr <= shift_byte[6:0];
            if (bit_cnt == 4'd0) begin
              bit_cnt  <= 4'd7;
              addr_reg <= addr_reg + 1'b1;
              if (wel) begin
                pw_en   <= 1'b1;
                pw_addr <= addr_reg;
                pw_data <= shift_byte;
              end
            end else begin
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
`endif
          default: cipo <= 1'b0;
        endcase
      end
    end
  end

  // Single write port: backdoor load wins over a protocol write in the same cycle.
  always_comb begin
    wr_en   = bus.load_en;
    wr_addr = bus.load_addr;
    wr_data = bus.load_data;
`ifdef VSLC_EEPROM_WRITE_EN
    if (!bus.load_en && pw_en) begin
      wr_en   = 1'b1;
      wr_addr = pw_addr;
      wr_data = pw_data;
    end
`endif
  end

  // Byte array with synchronous read; rd_q holds the byte being shifted out.
  always_ff @(posedge scan_cycle_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_req) rd_q <= mem[addr_reg];
  end

  assign bus.spi_cipo    = cipo;
  assign bus.spi_cipo_oe = (state == ST_DATA);
  assign bus.busy        = (state != ST_IDLE);
endmodule

// File: tb/tb_vslc_spi_eeprom_responder.sv
// Bench for vslc_spi_eeprom_responder: SPI mode-0 master tasks, a byte-array
// model of the EEPROM contents, directed scenarios and randomized reads.
module tb_vslc_spi_eeprom_responder;
  localparam int ADDR_W      = 10;
  localparam int SYNC_STAGES = 2;
  localparam int DEPTH       = 1 << ADDR_W;

  logic scan_cycle_clk = 1'b0;
  logic rst_n = 1'b0;

  vslc_spi_eeprom_responder_if #(.ADDR_W(ADDR_W)) bus ();

  vslc_spi_eeprom_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .scan_cycle_clk(scan_cycle_clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 scan_cycle_clk = ~scan_cycle_clk;

  logic [7:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Half an SCK period: 6 block clocks, so SCK is 12x slower than scan_cycle_clk.
  task automatic half_bit();
    repeat (6) @(negedge scan_cycle_clk);
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge scan_cycle_clk);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    @(negedge scan_cycle_clk);
    bus.load_en = 1'b0;
    model_mem[a] = d;
  endtask

  // Shift nbits of tx MSB-first; CIPO and OE are sampled just before each rise.
  task automatic shift_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic [7:0] oe);
    rx = '0;
    oe = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_copi = tx[i];
      half_bit();
      rx = {rx[6:0], bus.spi_cipo};
      oe = {oe[6:0], bus.spi_cipo_oe};
      bus.spi_sck = 1'b1;
      half_bit();
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    bus.spi_cs_n = 1'b0;
    half_bit();
  endtask

  task automatic cs_high();
    half_bit();
    bus.spi_cs_n = 1'b1;
    half_bit();
    half_bit();
  endtask

  task automatic send_header(input logic [7:0] op, input logic [15:0] addr);
    logic [7:0] rx, oe;
    shift_bits(op, 8, rx, oe);
    shift_bits(addr[15:8], 8, rx, oe);
    shift_bits(addr[7:0], 8, rx, oe);
  endtask

  task automatic do_read(input logic [15:0] addr, input int n, input string tag);
    logic [7:0] rx, oe;
    logic [ADDR_W-1:0] a;
    cs_low();
    send_header(8'h03, addr);
    a = addr[ADDR_W-1:0];
    for (int i = 0; i < n; i++) begin
      shift_bits(8'($urandom), 8, rx, oe);
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx}, {24'd0, model_mem[a]});
      check($sformatf("%s_oe%0d", tag, i), {24'd0, oe}, 32'hFF);
      a = a + 1'b1;
    end
    cs_high();
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                          input string tag);
    logic [7:0] rx, oe;
    cs_low();
    send_header(8'h02, addr);
    shift_bits(d0, 8, rx, oe);
    check({tag, "_oe0"}, {24'd0, oe}, 32'h0);
    shift_bits(d1, 8, rx, oe);
    check({tag, "_oe1"}, {24'd0, oe}, 32'h0);
    shift_bits(8'hFF, 5, rx, oe);
    cs_high();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx, oe;
    logic [7:0] t0, t1;
    bus.spi_sck   = 1'b0;
    bus.spi_cs_n  = 1'b1;
    bus.spi_copi  = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;

    repeat (4) @(posedge scan_cycle_clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_cipo", {31'd0, bus.spi_cipo}, 32'd0);
    check("rst_oe", {31'd0, bus.spi_cipo_oe}, 32'd0);
    @(negedge scan_cycle_clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) load(i[ADDR_W-1:0], 8'($urandom));

    // Header bytes at the bottom of the array.
    load(10'd0, 8'h00);
    load(10'd1, 8'h04);
    load(10'd2, 8'h00);
    load(10'd3, 8'h07);
    load(10'd4, 8'hA5);
    do_read(16'h0000, 5, "hdr");

    // Wrap from the top of the array straight into address 0.
    load(10'd1023, 8'h3C);
    load(10'd0, 8'hC3);
    do_read(16'h03FF, 2, "wrap");

    // Abort after 3 data bits, then re-read the same byte in full.
    cs_low();
    send_header(8'h03, 16'h0004);
    shift_bits(8'h00, 3, rx, oe);
    check("abort_partial", {29'd0, rx[2:0]}, {29'd0, model_mem[4][7:5]});
    check("abort_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.spi_cs_n = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge scan_cycle_clk);
    #1;
    check("abort_busy_after", {31'd0, bus.busy}, 32'd0);
    check("abort_oe_after", {31'd0, bus.spi_cipo_oe}, 32'd0);
    half_bit();
    half_bit();
    do_read(16'h0004, 1, "reread");

    // Unknown opcode: CIPO and OE stay low for the rest of the transaction.
    cs_low();
    shift_bits(8'h9F, 8, rx, oe);
    shift_bits(8'($urandom), 8, rx, oe);
    check("ign_cipo0", {24'd0, rx}, 32'h0);
    check("ign_oe0", {24'd0, oe}, 32'h0);
    shift_bits(8'($urandom), 8, rx, oe);
    check("ign_cipo1", {24'd0, rx}, 32'h0);
    check("ign_oe1", {24'd0, oe}, 32'h0);
    cs_high();
    do_read(16'h0003, 2, "after_ign");

    // Reset pulse in the middle of the address phase.
    cs_low();
    shift_bits(8'h03, 8, rx, oe);
    shift_bits(8'h00, 8, rx, oe);
    shift_bits(8'h01, 4, rx, oe);
    @(negedge scan_cycle_clk);
    rst_n = 1'b0;
    @(posedge scan_cycle_clk);
    #1;
    check("midrst_cipo", {31'd0, bus.spi_cipo}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge scan_cycle_clk);
    rst_n = 1'b1;
    bus.spi_cs_n = 1'b1;
    half_bit();
    half_bit();
    do_read(16'h0001, 1, "postrst");
    check("postrst_const", {24'd0, model_mem[1]}, 32'h04);

    // WRITE without a preceding WREN must leave the array untouched.
    t0 = model_mem[16];
    t1 = model_mem[17];
    do_write(16'h0010, ~t0, ~t1, "wr_nowren");
    do_read(16'h0010, 2, "nowren_rd");

`ifdef VSLC_EEPROM_WRITE_EN
    cs_low();
    shift_bits(8'h06, 8, rx, oe);
    cs_high();
    do_write(16'h0010, 8'h5A, 8'h6B, "wr_wren");
    model_mem[16] = 8'h5A;
    model_mem[17] = 8'h6B;
    do_read(16'h0010, 2, "wren_rd");
    // Latch was cleared by the CS rise ending the WRITE.
    do_write(16'h0010, 8'h11, 8'h22, "wr_again");
    do_read(16'h0010, 2, "latch_clr_rd");
`endif

    // Randomized backdoor loads and reads, including upper address bits and wrap.
    for (int it = 0; it < 16; it++) begin
      for (int k = 0; k < 3; k++) load(ADDR_W'($urandom), 8'($urandom));
      do_read(16'($urandom), int'($urandom_range(1, 4)), $sformatf("rand%0d", it));
    end
    do_read(16'hFFFE, 3, "rand_wrap");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
